// File: rtl/board_pkg.sv
// Shared types for the two-player ship-grid controller: cell codes,
// response codes, request modes and request FSM states.
package board_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    RESP_REJECT = 2'b00,
    RESP_PLACED = 2'b01,
    RESP_HIT    = 2'b10,
    RESP_MISS   = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    MODE_IDLE        = 2'b00,
    MODE_PLACE_HOST  = 2'b01,
    MODE_PLACE_GUEST = 2'b10,
    MODE_BATTLE      = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/board_cell_array.sv
// One player's GRID x GRID cell store: synchronous write port, a
// combinational peek port for the request evaluator and a registered
// render read port. Out-of-range addresses read as EMPTY.
module board_cell_array
  import board_pkg::*;
#(
  parameter int GRID = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] wx,
  input  logic [3:0] wy,
  input  cell_t      wdata,
  input  logic [3:0] px,
  input  logic [3:0] py,
  output cell_t      peek,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output cell_t      rd_code
);

  localparam logic [3:0] GRID_L = 4'(GRID);

  cell_t cells [GRID][GRID];

  // Cell storage: cleared on reset, one cell written per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < GRID; i++)
        for (int j = 0; j < GRID; j++)
          cells[i][j] <= CELL_EMPTY;
    end else if (we && wx < GRID_L && wy < GRID_L) begin
      cells[wy][wx] <= wdata;
    end
  end

  // Evaluator peek: same-cycle view of the target cell.
  always_comb begin
    peek = CELL_EMPTY;
    if (px < GRID_L && py < GRID_L) peek = cells[py][px];
  end

  // Render port: registered, so a same-cycle write shows the old value.
  always_ff @(posedge clk) begin
    if (rst)                                rd_code <= CELL_EMPTY;
    else if (rd_x < GRID_L && rd_y < GRID_L) rd_code <= cells[rd_y][rd_x];
    else                                    rd_code <= CELL_EMPTY;
  end

endmodule

// File: rtl/battle_board.sv
// Two-player ship-grid controller: placement validation, turn-ordered
// shots, remaining-ship tracking and winner detection.
// Optional build macro BOARD_FOG_EN hides unhit guest ships on the
// guest render port.
module battle_board
  import board_pkg::*;
#(
  parameter int GRID       = 10,
  parameter int SHIP_CELLS = 4,
  parameter int CW         = $clog2(GRID*GRID+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_player,
  input  logic [3:0]    req_x,
  input  logic [3:0]    req_y,
  output logic          resp_valid,
  output logic [1:0]    resp_code,
  input  logic [3:0]    rd_x,
  input  logic [3:0]    rd_y,
  output logic [1:0]    rd_code_host,
  output logic [1:0]    rd_code_guest,
  output logic [CW-1:0] placed_host,
  output logic [CW-1:0] placed_guest,
  output logic [CW-1:0] left_host,
  output logic [CW-1:0] left_guest,
  output logic          turn,
  output logic          game_over,
  output logic          winner
);

  localparam logic [3:0]    GRID_L = 4'(GRID);
  localparam logic [CW-1:0] SHIPS  = CW'(SHIP_CELLS);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t     state;
  mode_t      l_mode;
  logic       l_player;
  logic [3:0] l_x, l_y;

  cell_t h_peek, g_peek, h_rd, g_rd, tgt_cell, wr_data;
  resp_t res;
  logic  wr_ok, tgt_g, in_b;

  // Decide the outcome of the latched request from the target cell.
  always_comb begin
    res      = RESP_REJECT;
    wr_ok    = 1'b0;
    tgt_g    = 1'b0;
    wr_data  = CELL_SHIP;
    in_b     = (l_x < GRID_L) && (l_y < GRID_L);
    tgt_cell = h_peek;
    case (l_mode)
      MODE_PLACE_HOST: begin
        if (in_b && h_peek == CELL_EMPTY && placed_host < SHIPS) begin
          res   = RESP_PLACED;
          wr_ok = 1'b1;
        end
      end
      MODE_PLACE_GUEST: begin
        tgt_g = 1'b1;
        if (in_b && g_peek == CELL_EMPTY && placed_guest < SHIPS) begin
          res   = RESP_PLACED;
          wr_ok = 1'b1;
        end
      end
      MODE_BATTLE: begin
        tgt_g    = ~l_player;
        tgt_cell = tgt_g ? g_peek : h_peek;
        if (placed_host == SHIPS && placed_guest == SHIPS && !game_over &&
            l_player == turn && in_b &&
            (tgt_cell == CELL_EMPTY || tgt_cell == CELL_SHIP)) begin
          wr_ok = 1'b1;
          if (tgt_cell == CELL_SHIP) begin
            res     = RESP_HIT;
            wr_data = CELL_HIT;
          end else begin
            res     = RESP_MISS;
            wr_data = CELL_MISS;
          end
        end
      end
      default: ;
    endcase
  end

  // Request FSM; results and counters land as the FSM enters ST_RESP so
  // they are visible in the resp_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      l_mode       <= MODE_IDLE;
      l_player     <= 1'b0;
      l_x          <= '0;
      l_y          <= '0;
      resp_valid   <= 1'b0;
      resp_code    <= RESP_REJECT;
      placed_host  <= '0;
      placed_guest <= '0;
      left_host    <= '0;
      left_guest   <= '0;
      turn         <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          l_mode   <= mode_t'(mode);
          l_player <= req_player;
          l_x      <= req_x;
          l_y      <= req_y;
          state    <= ST_EVAL;
        end
        ST_EVAL: begin
          resp_valid <= 1'b1;
          resp_code  <= res;
          state      <= ST_RESP;
          if (wr_ok && l_mode == MODE_PLACE_HOST) begin
            placed_host <= placed_host + ONE;
            left_host   <= left_host + ONE;
          end
          if (wr_ok && l_mode == MODE_PLACE_GUEST) begin
            placed_guest <= placed_guest + ONE;
            left_guest   <= left_guest + ONE;
          end
          if (wr_ok && l_mode == MODE_BATTLE) begin
            turn <= ~turn;
            if (res == RESP_HIT) begin
              if (tgt_g) left_guest <= left_guest - ONE;
              else       left_host  <= left_host - ONE;
              if ((tgt_g ? left_guest : left_host) == ONE) begin
                game_over <= 1'b1;
                winner    <= l_player;
              end
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);

  board_cell_array #(.GRID(GRID)) u_host (
    .clk(clk), .rst(rst),
    .we(state == ST_EVAL && wr_ok && !tgt_g), .wx(l_x), .wy(l_y), .wdata(wr_data),
    .px(l_x), .py(l_y), .peek(h_peek),
    .rd_x(rd_x), .rd_y(rd_y), .rd_code(h_rd)
  );

  board_cell_array #(.GRID(GRID)) u_guest (
    .clk(clk), .rst(rst),
    .we(state == ST_EVAL && wr_ok && tgt_g), .wx(l_x), .wy(l_y), .wdata(wr_data),
    .px(l_x), .py(l_y), .peek(g_peek),
    .rd_x(rd_x), .rd_y(rd_y), .rd_code(g_rd)
  );

  assign rd_code_host = h_rd;
`ifdef BOARD_FOG_EN
  assign rd_code_guest = (g_rd == CELL_SHIP) ? CELL_EMPTY : g_rd;
`else
  assign rd_code_guest = g_rd;
`endif

endmodule

// File: tb/tb_battle_board.sv
// Directed, table-driven bench for battle_board (GRID=10, SHIP_CELLS=4).
// Expectations for the guest render port follow BOARD_FOG_EN.
module tb_battle_board;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_player = 1'b0;
  logic [3:0]    req_x = '0, req_y = '0;
  logic          resp_valid;
  logic [1:0]    resp_code;
  logic [3:0]    rd_x = '0, rd_y = '0;
  logic [1:0]    rd_code_host, rd_code_guest;
  logic [CW-1:0] placed_host, placed_guest, left_host, left_guest;
  logic          turn, game_over, winner;

  int checks = 0;
  int errors = 0;

  battle_board #(.GRID(10), .SHIP_CELLS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req_ready(req_ready),
    .req_player(req_player), .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_code(resp_code),
    .rd_x(rd_x), .rd_y(rd_y), .rd_code_host(rd_code_host), .rd_code_guest(rd_code_guest),
    .placed_host(placed_host), .placed_guest(placed_guest),
    .left_host(left_host), .left_guest(left_guest),
    .turn(turn), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic       p;
    logic [3:0] x, y;
    logic [1:0] code;
    int         ph, pg, lh, lg;
    logic       turn, go;
  } vec_t;

  vec_t vq[$];

`ifdef BOARD_FOG_EN
  localparam logic [1:0] G_SHIP_VIEW = 2'b00;
`else
  localparam logic [1:0] G_SHIP_VIEW = 2'b01;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One request: drive, check the two-cycle latency and single-cycle pulse.
  task automatic do_req(input string tag, input logic [1:0] m, input logic p,
                        input logic [3:0] x, input logic [3:0] y,
                        output logic [1:0] code, output logic go_r);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, int'(req_ready), 1);
    mode = m; req_player = p; req_x = x; req_y = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mode = 2'b00; req_player = ~p;       // latched values must govern
    @(negedge clk);
    chk({tag, " no early resp"}, int'(resp_valid), 0);
    @(negedge clk);
    chk({tag, " resp_valid"}, int'(resp_valid), 1);
    code = resp_code;
    go_r = game_over;
    @(negedge clk);
    chk({tag, " resp pulse ends"}, int'(resp_valid), 0);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [1:0] eh, input logic [1:0] eg);
    @(negedge clk);
    rd_x = x; rd_y = y;
    @(negedge clk);
    chk({tag, " rd_host"}, int'(rd_code_host), int'(eh));
    chk({tag, " rd_guest"}, int'(rd_code_guest), int'(eg));
  endtask

  initial begin
    logic [1:0] code;
    logic       go_r;
    int         seen;

    //          mode   p     x     y     code   ph pg lh lg turn  go
    vq.push_back('{2'b01, 1'b0, 4'd2, 4'd3, 2'b01, 1, 0, 1, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd2, 4'd3, 2'b00, 1, 0, 1, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd10,4'd0, 2'b00, 1, 0, 1, 0, 1'b0, 1'b0});
    vq.push_back('{2'b00, 1'b0, 4'd0, 4'd0, 2'b00, 1, 0, 1, 0, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 1, 0, 1, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd0, 4'd0, 2'b01, 2, 0, 2, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd1, 4'd0, 2'b01, 3, 0, 3, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd9, 4'd9, 2'b01, 4, 0, 4, 0, 1'b0, 1'b0});
    vq.push_back('{2'b01, 1'b0, 4'd5, 4'd5, 2'b00, 4, 0, 4, 0, 1'b0, 1'b0});
    vq.push_back('{2'b10, 1'b0, 4'd0, 4'd0, 2'b01, 4, 1, 4, 1, 1'b0, 1'b0});
    vq.push_back('{2'b10, 1'b0, 4'd1, 4'd1, 2'b01, 4, 2, 4, 2, 1'b0, 1'b0});
    vq.push_back('{2'b10, 1'b0, 4'd2, 4'd2, 2'b01, 4, 3, 4, 3, 1'b0, 1'b0});
    vq.push_back('{2'b10, 1'b0, 4'd3, 4'd3, 2'b01, 4, 4, 4, 4, 1'b0, 1'b0});
    // battle
    vq.push_back('{2'b11, 1'b1, 4'd0, 4'd0, 2'b00, 4, 4, 4, 4, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd0, 4'd0, 2'b10, 4, 4, 4, 3, 1'b1, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd1, 4'd1, 2'b00, 4, 4, 4, 3, 1'b1, 1'b0});
    vq.push_back('{2'b11, 1'b1, 4'd5, 4'd5, 2'b11, 4, 4, 4, 3, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd0, 4'd0, 2'b00, 4, 4, 4, 3, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd1, 4'd1, 2'b10, 4, 4, 4, 2, 1'b1, 1'b0});
    vq.push_back('{2'b11, 1'b1, 4'd6, 4'd6, 2'b11, 4, 4, 4, 2, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd2, 4'd2, 2'b10, 4, 4, 4, 1, 1'b1, 1'b0});
    vq.push_back('{2'b11, 1'b1, 4'd6, 4'd6, 2'b00, 4, 4, 4, 1, 1'b1, 1'b0});
    vq.push_back('{2'b11, 1'b1, 4'd7, 4'd7, 2'b11, 4, 4, 4, 1, 1'b0, 1'b0});
    vq.push_back('{2'b11, 1'b0, 4'd3, 4'd3, 2'b10, 4, 4, 4, 0, 1'b1, 1'b1});
    vq.push_back('{2'b11, 1'b1, 4'd8, 4'd8, 2'b00, 4, 4, 4, 0, 1'b1, 1'b1});
    vq.push_back('{2'b10, 1'b0, 4'd9, 4'd9, 2'b00, 4, 4, 4, 0, 1'b1, 1'b1});

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("reset resp_valid", int'(resp_valid), 0);
    chk("reset resp_code", int'(resp_code), 0);
    chk("reset placed_host", int'(placed_host), 0);
    chk("reset left_guest", int'(left_guest), 0);
    chk("reset turn", int'(turn), 0);
    chk("reset game_over", int'(game_over), 0);
    chk("reset ready", int'(req_ready), 1);
    chk("reset rd_host", int'(rd_code_host), 0);

    foreach (vq[i]) begin
      if (i == 13) begin
        rd_chk("pre host ship", 4'd0, 4'd0, 2'b01, G_SHIP_VIEW);
        rd_chk("pre (2,3)", 4'd2, 4'd3, 2'b01, 2'b00);
        rd_chk("pre oob", 4'd12, 4'd0, 2'b00, 2'b00);
      end
      do_req($sformatf("v%0d", i), vq[i].mode, vq[i].p, vq[i].x, vq[i].y, code, go_r);
      chk($sformatf("v%0d code", i), int'(code), int'(vq[i].code));
      chk($sformatf("v%0d go@resp", i), int'(go_r), int'(vq[i].go));
      chk($sformatf("v%0d placed_host", i), int'(placed_host), vq[i].ph);
      chk($sformatf("v%0d placed_guest", i), int'(placed_guest), vq[i].pg);
      chk($sformatf("v%0d left_host", i), int'(left_host), vq[i].lh);
      chk($sformatf("v%0d left_guest", i), int'(left_guest), vq[i].lg);
      chk($sformatf("v%0d turn", i), int'(turn), int'(vq[i].turn));
      chk($sformatf("v%0d winner", i), int'(winner), 0);
    end

    rd_chk("post (0,0)", 4'd0, 4'd0, 2'b01, 2'b10);
    rd_chk("post (5,5)", 4'd5, 4'd5, 2'b11, 2'b00);
    rd_chk("post (3,3)", 4'd3, 4'd3, 2'b00, 2'b10);
    rd_chk("post (9,9)", 4'd9, 4'd9, 2'b01, 2'b00);

    // Reset during ST_EVAL aborts the request and clears the boards.
    @(negedge clk);
    mode = 2'b01; req_player = 1'b0; req_x = 4'd4; req_y = 4'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mode = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort no resp", seen, 0);
    chk("abort placed_host", int'(placed_host), 0);
    chk("abort left_guest", int'(left_guest), 0);
    chk("abort game_over", int'(game_over), 0);
    chk("abort turn", int'(turn), 0);
    rd_chk("abort (0,0)", 4'd0, 4'd0, 2'b00, 2'b00);
    rd_chk("abort (3,3)", 4'd3, 4'd3, 2'b00, 2'b00);
    do_req("after abort", 2'b01, 1'b0, 4'd4, 4'd4, code, go_r);
    chk("after abort code", int'(code), 1);
    chk("after abort placed_host", int'(placed_host), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
